// File: rtl/hazard_unit_tr.sv
// Hazard controller for the 5-stage RV32 core: M/W forwarding, load-use stall,
// branch flush and time-redundant E-stage re-execution (compare or 3-way vote).

module hazard_fwd_lane #(
  parameter int REG_AW = 5
) (
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [REG_AW-1:0] RD_W,
  input  logic [REG_AW-1:0] rs,
  output logic [1:0]        fwd
);
  always_comb begin
    fwd = 2'b00;
    if (RegWriteM && RD_M != '0 && RD_M == rs)      fwd = 2'b10;
    else if (RegWriteW && RD_W != '0 && RD_W == rs) fwd = 2'b01;
  end
endmodule

module hazard_unit_tr #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int N_EXEC    = 2,
  parameter int MAX_RETRY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [REG_AW-1:0] RD_W,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              RedundE,
  input  logic [XLEN-1:0]   ALUResultE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              StallW,
  output logic              FlushD,
  output logic              FlushE,
  output logic [XLEN-1:0]   ALUVotedE,
  output logic              RedunBusy,
  output logic              RedunCorrected,
  output logic              RedunFault
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;
  localparam int PW = $clog2(N_EXEC);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [PW-1:0] LAST = PW'(N_EXEC - 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

  logic [0:0]                   state;
  logic [PW-1:0]                pass_cnt;
  logic [RW-1:0]                retry_cnt;
  logic [N_EXEC-2:0][XLEN-1:0]  copy;

  logic [1:0][REG_AW-1:0] rs_e;
  logic [1:0][1:0]        fwd;
  assign rs_e = {Rs2_E, Rs1_E};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    hazard_fwd_lane #(.REG_AW(REG_AW)) u_lane (
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .RD_M(RD_M), .RD_W(RD_W), .rs(rs_e[g]), .fwd(fwd[g])
    );
  end

  logic            agree, vote_corr;
  logic [XLEN-1:0] vote_val;

  // The current ALU output is always the final copy; only earlier passes are stored.
  if (N_EXEC == 2) begin : g_cmp
    assign agree     = (copy[0] == ALUResultE);
    assign vote_val  = ALUResultE;
    assign vote_corr = 1'b0;
  end else if (N_EXEC == 3) begin : g_vote
    logic ab, ac, bc;
    assign ab        = (copy[0] == copy[1]);
    assign ac        = (copy[0] == ALUResultE);
    assign bc        = (copy[1] == ALUResultE);
    assign agree     = ab | ac | bc;
    assign vote_val  = (ab | ac) ? copy[0] : copy[1];
    assign vote_corr = agree & ~(ab & ac);
  end else begin : g_bad
    $error("hazard_unit_tr: N_EXEC must be 2 or 3");
  end

  logic deciding, can_retry, capture;
  logic redstall, fault, corrected, lw;
  logic [XLEN-1:0] voted;

  assign deciding  = (state == EXEC) && (pass_cnt == LAST);
  assign can_retry = (retry_cnt != RMAX);
  assign capture   = ((state == IDLE) && RedundE) || ((state == EXEC) && !deciding);
  assign lw        = LoadE && RD_E != '0 && (RD_E == Rs1_D || RD_E == Rs2_D);

  always_comb begin
    redstall  = 1'b0;
    fault     = 1'b0;
    corrected = 1'b0;
    voted     = ALUResultE;
    if (state == IDLE)    redstall = RedundE;
    else if (!deciding)   redstall = 1'b1;
    else if (agree) begin
      voted     = vote_val;
      corrected = vote_corr;
    end
    else if (can_retry)   redstall = 1'b1;
    else                  fault    = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pass_cnt  <= '0;
      retry_cnt <= '0;
    end else if (capture) begin
      state    <= EXEC;
      pass_cnt <= pass_cnt + PW'(1);
    end else if (state == EXEC) begin
      if (!agree && can_retry) begin
        retry_cnt <= retry_cnt + RW'(1);
        pass_cnt  <= '0;
      end else begin
        state     <= IDLE;
        pass_cnt  <= '0;
        retry_cnt <= '0;
      end
    end
  end

  for (genvar k = 0; k < N_EXEC - 1; k++) begin : g_copy
    always_ff @(posedge clk) begin
      if (rst)                                     copy[k] <= '0;
      else if (capture && pass_cnt == PW'(k))      copy[k] <= ALUResultE;
    end
  end

  // Everything combinational is held low while reset is asserted.
  assign ForwardAE      = rst ? 2'b00 : fwd[0];
  assign ForwardBE      = rst ? 2'b00 : fwd[1];
  assign StallF         = !rst && (lw || redstall);
  assign StallD         = StallF;
  assign StallE         = !rst && redstall;
  assign StallM         = StallE;
  assign StallW         = StallE;
  assign FlushE         = !rst && (lw || PCSrcE) && !redstall;
  assign FlushD         = !rst && PCSrcE && !redstall;
  assign ALUVotedE      = rst ? '0 : voted;
  assign RedunBusy      = !rst && (state == EXEC);
  assign RedunCorrected = !rst && corrected;
  assign RedunFault     = !rst && fault;
endmodule

// File: tb/tb_hazard_unit_tr.sv
// Directed bench for hazard_unit_tr: a compare (N=2, one retry) and a vote
// (N=3, no retry) instance share stimulus; expectations flow through a queue.
module tb_hazard_unit_tr;
  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, RegWriteW, LoadE, PCSrcE, RedundE;
  logic [4:0]  RD_M, RD_W, RD_E, Rs1_E, Rs2_E, Rs1_D, Rs2_D;
  logic [31:0] ALUResultE;

  logic [1:0]  fa2, fb2, fa3, fb3;
  logic        sf2, sd2, se2, sm2, sw2, fd2, fe2, busy2, corr2, flt2;
  logic        sf3, sd3, se3, sm3, sw3, fd3, fe3, busy3, corr3, flt3;
  logic [31:0] v2, v3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          dut;
    logic [1:0]  fa, fb;
    logic [4:0]  st;
    logic [1:0]  fl;
    logic [31:0] v;
    logic [2:0]  pul;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  hazard_unit_tr #(.XLEN(32), .REG_AW(5), .N_EXEC(2), .MAX_RETRY(1)) dut2 (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .RD_M(RD_M), .RD_W(RD_W), .RD_E(RD_E), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .LoadE(LoadE), .PCSrcE(PCSrcE),
    .RedundE(RedundE), .ALUResultE(ALUResultE), .ForwardAE(fa2), .ForwardBE(fb2),
    .StallF(sf2), .StallD(sd2), .StallE(se2), .StallM(sm2), .StallW(sw2),
    .FlushD(fd2), .FlushE(fe2), .ALUVotedE(v2), .RedunBusy(busy2),
    .RedunCorrected(corr2), .RedunFault(flt2));

  hazard_unit_tr #(.XLEN(32), .REG_AW(5), .N_EXEC(3), .MAX_RETRY(0)) dut3 (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .RD_M(RD_M), .RD_W(RD_W), .RD_E(RD_E), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .LoadE(LoadE), .PCSrcE(PCSrcE),
    .RedundE(RedundE), .ALUResultE(ALUResultE), .ForwardAE(fa3), .ForwardBE(fb3),
    .StallF(sf3), .StallD(sd3), .StallE(se3), .StallM(sm3), .StallW(sw3),
    .FlushD(fd3), .FlushE(fe3), .ALUVotedE(v3), .RedunBusy(busy3),
    .RedunCorrected(corr3), .RedunFault(flt3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    rst = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; LoadE = 1'b0; PCSrcE = 1'b0;
    RedundE = 1'b0; RD_M = '0; RD_W = '0; RD_E = '0; Rs1_E = '0; Rs2_E = '0;
    Rs1_D = '0; Rs2_D = '0; ALUResultE = '0;
  endtask

  task automatic do_reset();
    clear();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Push the expectation for the inputs just driven, then pop and compare at negedge.
  task automatic step(input string tag, input int d, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [4:0] st, input logic [1:0] fl, input logic [31:0] v,
                      input logic [2:0] pul);
    exp_t e, o;
    e.tag = tag; e.dut = d; e.fa = fa; e.fb = fb; e.st = st; e.fl = fl; e.v = v; e.pul = pul;
    q.push_back(e);
    @(negedge clk);
    o = q.pop_front();
    if (o.dut == 2) begin
      chk({o.tag, "_fwd"},   {28'd0, fa2, fb2}, {28'd0, o.fa, o.fb});
      chk({o.tag, "_stall"}, {27'd0, sf2, sd2, se2, sm2, sw2}, {27'd0, o.st});
      chk({o.tag, "_flush"}, {30'd0, fd2, fe2}, {30'd0, o.fl});
      chk({o.tag, "_voted"}, v2, o.v);
      chk({o.tag, "_flags"}, {29'd0, busy2, corr2, flt2}, {29'd0, o.pul});
    end else begin
      chk({o.tag, "_fwd"},   {28'd0, fa3, fb3}, {28'd0, o.fa, o.fb});
      chk({o.tag, "_stall"}, {27'd0, sf3, sd3, se3, sm3, sw3}, {27'd0, o.st});
      chk({o.tag, "_flush"}, {30'd0, fd3, fe3}, {30'd0, o.fl});
      chk({o.tag, "_voted"}, v3, o.v);
      chk({o.tag, "_flags"}, {29'd0, busy3, corr3, flt3}, {29'd0, o.pul});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset forces every combinational output low despite active inputs
    clear();
    rst = 1'b1; RegWriteM = 1'b1; RD_M = 5'd5; Rs1_E = 5'd5; LoadE = 1'b1; RD_E = 5'd7;
    Rs1_D = 5'd7; RedundE = 1'b1; PCSrcE = 1'b1; ALUResultE = 32'h55;
    step("rst2", 2, 2'b00, 2'b00, 5'b00000, 2'b00, 32'h0, 3'b000);
    step("rst3", 3, 2'b00, 2'b00, 5'b00000, 2'b00, 32'h0, 3'b000);

    // forwarding
    clear();
    RegWriteM = 1'b1; RD_M = 5'd5; RegWriteW = 1'b1; RD_W = 5'd5; Rs1_E = 5'd5;
    ALUResultE = 32'h77;
    step("fwd_m", 2, 2'b10, 2'b00, 5'b00000, 2'b00, 32'h77, 3'b000);
    RD_M = 5'd0;
    step("fwd_w", 2, 2'b01, 2'b00, 5'b00000, 2'b00, 32'h77, 3'b000);
    RD_M = 5'd5; Rs2_E = 5'd5;
    step("fwd_mb", 2, 2'b10, 2'b10, 5'b00000, 2'b00, 32'h77, 3'b000);
    RegWriteM = 1'b0;
    step("fwd_wb", 2, 2'b01, 2'b01, 5'b00000, 2'b00, 32'h77, 3'b000);
    RD_W = 5'd0;
    step("fwd_none", 2, 2'b00, 2'b00, 5'b00000, 2'b00, 32'h77, 3'b000);

    // load-use
    clear();
    LoadE = 1'b1; RD_E = 5'd7; Rs2_D = 5'd7;
    step("lw_rs2", 2, 2'b00, 2'b00, 5'b11000, 2'b01, 32'h0, 3'b000);
    RD_E = 5'd0;
    step("lw_x0", 2, 2'b00, 2'b00, 5'b00000, 2'b00, 32'h0, 3'b000);
    RD_E = 5'd3; Rs1_D = 5'd3; Rs2_D = 5'd0;
    step("lw_rs1", 2, 2'b00, 2'b00, 5'b11000, 2'b01, 32'h0, 3'b000);
    LoadE = 1'b0;
    step("lw_off", 2, 2'b00, 2'b00, 5'b00000, 2'b00, 32'h0, 3'b000);

    // N=2 clean
    clear();
    RedundE = 1'b1; ALUResultE = 32'h1234;
    step("n2_p0", 2, 2'b00, 2'b00, 5'b11111, 2'b00, 32'h1234, 3'b000);
    step("n2_p1", 2, 2'b00, 2'b00, 5'b00000, 2'b00, 32'h1234, 3'b100);
    RedundE = 1'b0; ALUResultE = 32'h42;
    step("n2_idle", 2, 2'b00, 2'b00, 5'b00000, 2'b00, 32'h42, 3'b000);

    // N=2 mismatch recovered by retry
    RedundE = 1'b1; ALUResultE = 32'hA;
    step("rt_p0", 2, 2'b00, 2'b00, 5'b11111, 2'b00, 32'hA, 3'b000);
    ALUResultE = 32'hB;
    step("rt_p1", 2, 2'b00, 2'b00, 5'b11111, 2'b00, 32'hB, 3'b100);
    ALUResultE = 32'hA;
    step("rt_p2", 2, 2'b00, 2'b00, 5'b11111, 2'b00, 32'hA, 3'b100);
    step("rt_p3", 2, 2'b00, 2'b00, 5'b00000, 2'b00, 32'hA, 3'b100);
    RedundE = 1'b0; ALUResultE = 32'h0;
    step("rt_idle", 2, 2'b00, 2'b00, 5'b00000, 2'b00, 32'h0, 3'b000);

    // N=2 retries exhausted
    RedundE = 1'b1; ALUResultE = 32'hA;
    step("flt_p0", 2, 2'b00, 2'b00, 5'b11111, 2'b00, 32'hA, 3'b000);
    ALUResultE = 32'hB;
    step("flt_p1", 2, 2'b00, 2'b00, 5'b11111, 2'b00, 32'hB, 3'b100);
    ALUResultE = 32'hC;
    step("flt_p2", 2, 2'b00, 2'b00, 5'b11111, 2'b00, 32'hC, 3'b100);
    ALUResultE = 32'hD;
    step("flt_p3", 2, 2'b00, 2'b00, 5'b00000, 2'b00, 32'hD, 3'b101);
    RedundE = 1'b0; ALUResultE = 32'h0;
    step("flt_idle", 2, 2'b00, 2'b00, 5'b00000, 2'b00, 32'h0, 3'b000);

    // retry budget restored after the fault
    RedundE = 1'b1; ALUResultE = 32'h3;
    step("rc_p0", 2, 2'b00, 2'b00, 5'b11111, 2'b00, 32'h3, 3'b000);
    ALUResultE = 32'h4;
    step("rc_p1", 2, 2'b00, 2'b00, 5'b11111, 2'b00, 32'h4, 3'b100);
    ALUResultE = 32'h3;
    step("rc_p2", 2, 2'b00, 2'b00, 5'b11111, 2'b00, 32'h3, 3'b100);
    step("rc_p3", 2, 2'b00, 2'b00, 5'b00000, 2'b00, 32'h3, 3'b100);

    // N=3 vote, no retry
    do_reset();
    RedundE = 1'b1; ALUResultE = 32'h5;
    step("v1_p0", 3, 2'b00, 2'b00, 5'b11111, 2'b00, 32'h5, 3'b000);
    ALUResultE = 32'h9;
    step("v1_p1", 3, 2'b00, 2'b00, 5'b11111, 2'b00, 32'h9, 3'b100);
    ALUResultE = 32'h5;
    step("v1_p2", 3, 2'b00, 2'b00, 5'b00000, 2'b00, 32'h5, 3'b110);
    RedundE = 1'b0; ALUResultE = 32'h0;
    step("v1_idle", 3, 2'b00, 2'b00, 5'b00000, 2'b00, 32'h0, 3'b000);
    RedundE = 1'b1; ALUResultE = 32'h7;
    step("v2_p0", 3, 2'b00, 2'b00, 5'b11111, 2'b00, 32'h7, 3'b000);
    ALUResultE = 32'h8;
    step("v2_p1", 3, 2'b00, 2'b00, 5'b11111, 2'b00, 32'h8, 3'b100);
    step("v2_p2", 3, 2'b00, 2'b00, 5'b00000, 2'b00, 32'h8, 3'b110);
    ALUResultE = 32'h1;
    RedundE = 1'b0;
    step("v2_idle", 3, 2'b00, 2'b00, 5'b00000, 2'b00, 32'h1, 3'b000);
    RedundE = 1'b1;
    step("v3_p0", 3, 2'b00, 2'b00, 5'b11111, 2'b00, 32'h1, 3'b000);
    ALUResultE = 32'h2;
    step("v3_p1", 3, 2'b00, 2'b00, 5'b11111, 2'b00, 32'h2, 3'b100);
    ALUResultE = 32'h3;
    step("v3_p2", 3, 2'b00, 2'b00, 5'b00000, 2'b00, 32'h3, 3'b101);
    RedundE = 1'b0; ALUResultE = 32'h4;
    step("v3_idle", 3, 2'b00, 2'b00, 5'b00000, 2'b00, 32'h4, 3'b000);
    RedundE = 1'b1;
    step("v4_p0", 3, 2'b00, 2'b00, 5'b11111, 2'b00, 32'h4, 3'b000);
    step("v4_p1", 3, 2'b00, 2'b00, 5'b11111, 2'b00, 32'h4, 3'b100);
    step("v4_p2", 3, 2'b00, 2'b00, 5'b00000, 2'b00, 32'h4, 3'b100);

    // branch and load-use against the redundancy stall
    do_reset();
    RedundE = 1'b1; PCSrcE = 1'b1; LoadE = 1'b1; RD_E = 5'd7; Rs1_D = 5'd7; ALUResultE = 32'h6;
    step("br_p0", 2, 2'b00, 2'b00, 5'b11111, 2'b00, 32'h6, 3'b000);
    step("br_p1", 2, 2'b00, 2'b00, 5'b11000, 2'b11, 32'h6, 3'b100);
    clear();
    step("br_idle", 2, 2'b00, 2'b00, 5'b00000, 2'b00, 32'h0, 3'b000);

    // reset mid-op: abandoned silently, next cycle idle
    RedundE = 1'b1; ALUResultE = 32'h11;
    step("rm_p0", 2, 2'b00, 2'b00, 5'b11111, 2'b00, 32'h11, 3'b000);
    rst = 1'b1; ALUResultE = 32'h22;
    step("rm_rst", 2, 2'b00, 2'b00, 5'b00000, 2'b00, 32'h0, 3'b000);
    clear();
    step("rm_idle", 2, 2'b00, 2'b00, 5'b00000, 2'b00, 32'h0, 3'b000);
    RedundE = 1'b1; ALUResultE = 32'h11;
    step("rm_new", 2, 2'b00, 2'b00, 5'b11111, 2'b00, 32'h11, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
